// File: rtl/alu_issue_stage.sv
// Issue stage in front of the ALU: decodes instruction words, reads the register file with
// writeback bypass, tracks outstanding destinations and stalls on RAW/WAW hazards.
module alu_issue_stage #(
  parameter int NREG = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] instr,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] op_a,
  output logic [31:0] op_b,
  output logic [3:0]  opcode,
  output logic [2:0]  sr_cont,
  output logic [4:0]  sr_bit,
  output logic [3:0]  rd_out,
  input  logic        wb_en,
  input  logic [3:0]  wb_addr,
  input  logic [31:0] wb_data,
  output logic        illegal_op
);

  localparam logic [NREG-1:0] R0_MASK = NREG'(1);

  logic [31:0]     rf [NREG];
  logic [NREG-1:0] pending;

  logic [3:0]      dec_op;
  logic [3:0]      dec_rd;
  logic [3:0]      dec_rs1;
  logic [3:0]      dec_rs2;
  logic [2:0]      dec_sc;
  logic [4:0]      dec_sb;
  logic            unused_low_bits;

  logic [NREG-1:0] wb_clear;
  logic [NREG-1:0] pending_live;
  logic [NREG-1:0] set_mask;
  logic            hazard;
  logic            illegal;
  logic            transfer;
  logic            issue_legal;
  logic [31:0]     rs1_val;
  logic [31:0]     rs2_val;

  assign dec_op          = instr[31:28];
  assign dec_rd          = instr[27:24];
  assign dec_rs1         = instr[23:20];
  assign dec_rs2         = instr[19:16];
  assign dec_sc          = instr[15:13];
  assign dec_sb          = instr[12:8];
  assign unused_low_bits = ^instr[7:0];

  // A register being written back this cycle no longer blocks issue.
  assign wb_clear     = wb_en ? (NREG'(1) << wb_addr) : '0;
  assign pending_live = pending & ~wb_clear;

  assign hazard = in_valid && (((dec_rs1 != '0) && pending_live[dec_rs1]) ||
                               ((dec_rs2 != '0) && pending_live[dec_rs2]) ||
                               ((dec_rd  != '0) && pending_live[dec_rd]));

  assign illegal     = dec_op > 4'd5;
  assign in_ready    = (!out_valid || out_ready) && !hazard;
  assign transfer    = in_valid && in_ready;
  assign issue_legal = transfer && !illegal;
  assign set_mask    = (issue_legal && (dec_rd != '0)) ? (NREG'(1) << dec_rd) : '0;

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    rs1_val = rf[dec_rs1];
    rs2_val = rf[dec_rs2];
    if (dec_rs1 == '0)                         rs1_val = '0;
    else if (wb_en && (wb_addr == dec_rs1))    rs1_val = wb_data;
    if (dec_rs2 == '0)                         rs2_val = '0;
    else if (wb_en && (wb_addr == dec_rs2))    rs2_val = wb_data;
  end

  // NOTE: sequential state uses non-blocking assignments only, so every reader sees pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid  <= 1'b0;
      illegal_op <= 1'b0;
      op_a       <= '0;
      op_b       <= '0;
      opcode     <= '0;
      sr_cont    <= '0;
      sr_bit     <= '0;
      rd_out     <= '0;
      pending    <= '0;
      // NOTE: the register file is small and must read zero after reset, so it is cleared
      // explicitly here rather than left to power-up contents.
      for (int i = 0; i < NREG; i++) rf[i] <= '0;
    end else begin
      if (wb_en && (wb_addr != '0)) rf[wb_addr] <= wb_data;

      // Set beats clear when issue and writeback hit the same register.
      pending    <= (pending_live | set_mask) & ~R0_MASK;
      illegal_op <= transfer && illegal;

      if (issue_legal) begin
        out_valid <= 1'b1;
        op_a      <= rs1_val;
        op_b      <= rs2_val;
        opcode    <= dec_op;
        sr_cont   <= dec_sc;
        sr_bit    <= dec_sb;
        rd_out    <= dec_rd;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_alu_issue_stage.sv
// Self-checking bench for alu_issue_stage: table-driven burst plus hand-written hazard,
// hold, illegal-opcode, r0 and mid-hold reset sequences; bundles checked from a scoreboard.
module tb_alu_issue_stage;

  typedef struct {
    logic [31:0] op_a;
    logic [31:0] op_b;
    logic [3:0]  opcode;
    logic [2:0]  sr_cont;
    logic [4:0]  sr_bit;
    logic [3:0]  rd;
  } bundle_t;

  typedef struct {
    logic [31:0] word;
    bundle_t     exp;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] instr;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] op_a;
  logic [31:0] op_b;
  logic [3:0]  opcode;
  logic [2:0]  sr_cont;
  logic [4:0]  sr_bit;
  logic [3:0]  rd_out;
  logic        wb_en;
  logic [3:0]  wb_addr;
  logic [31:0] wb_data;
  logic        illegal_op;

  int checks   = 0;
  int failures = 0;
  bundle_t exp_q[$];
  vec_t    vec [6];

  alu_issue_stage #(.NREG(16)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .instr      (instr),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .op_a       (op_a),
    .op_b       (op_b),
    .opcode     (opcode),
    .sr_cont    (sr_cont),
    .sr_bit     (sr_bit),
    .rd_out     (rd_out),
    .wb_en      (wb_en),
    .wb_addr    (wb_addr),
    .wb_data    (wb_data),
    .illegal_op (illegal_op)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic bundle_t mkb(input logic [31:0] a, input logic [31:0] b, input logic [3:0] opc,
                                  input logic [2:0] sc, input logic [4:0] sb, input logic [3:0] rd);
    bundle_t r;
    r.op_a = a; r.op_b = b; r.opcode = opc; r.sr_cont = sc; r.sr_bit = sb; r.rd = rd;
    return r;
  endfunction

  function automatic vec_t mkv(input logic [31:0] w, input bundle_t e);
    vec_t v;
    v.word = w;
    v.exp  = e;
    return v;
  endfunction

  // Each consumed bundle is compared against the oldest expected entry.
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_bundle: got rd_out=%h with no expected entry", rd_out);
      end else begin
        bundle_t e;
        e = exp_q.pop_front();
        check("bundle_op_a",    op_a,    e.op_a);
        check("bundle_op_b",    op_b,    e.op_b);
        check("bundle_opcode",  32'(opcode),  32'(e.opcode));
        check("bundle_sr_cont", 32'(sr_cont), 32'(e.sr_cont));
        check("bundle_sr_bit",  32'(sr_bit),  32'(e.sr_bit));
        check("bundle_rd_out",  32'(rd_out),  32'(e.rd));
      end
    end
  end

  // Inputs change 2 time units after the rising edge.
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic wb(input logic [3:0] a, input logic [31:0] d);
    wb_en = 1'b1; wb_addr = a; wb_data = d;
    tick();
    wb_en = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec[0] = mkv(32'h0712_0000, mkb(32'd5,          32'd7,          4'd0, 3'd0, 5'd0,  4'd7));
    vec[1] = mkv(32'h1834_2400, mkb(32'h1234_5678,  32'hDEAD_BEEF,  4'd1, 3'd1, 5'd4,  4'd8));
    vec[2] = mkv(32'h2956_5F00, mkb(32'hFFFF_FFFF,  32'h8000_0001,  4'd2, 3'd2, 5'd31, 4'd9));
    vec[3] = mkv(32'h5A01_61AB, mkb(32'd0,          32'd5,          4'd5, 3'd3, 5'd1,  4'd10));
    vec[4] = mkv(32'h3022_0000, mkb(32'd7,          32'd7,          4'd3, 3'd0, 5'd0,  4'd0));
    vec[5] = mkv(32'h4B63_F000, mkb(32'h8000_0001,  32'h1234_5678,  4'd4, 3'd7, 5'd16, 4'd11));

    rst = 1'b1; in_valid = 1'b0; instr = '0; out_ready = 1'b1;
    wb_en = 1'b0; wb_addr = '0; wb_data = '0;
    tick(); tick();
    rst = 1'b0;
    #1;
    check("reset_out_valid",  32'(out_valid),  32'd0);
    check("reset_illegal_op", 32'(illegal_op), 32'd0);
    check("reset_op_a",       op_a,            32'd0);
    check("reset_op_b",       op_b,            32'd0);
    check("reset_rd_out",     32'(rd_out),     32'd0);
    check("reset_fields",     32'({opcode, sr_cont, sr_bit}), 32'd0);
    check("reset_in_ready",   32'(in_ready),   32'd1);
    #1;

    wb(4'd1, 32'd5);
    wb(4'd2, 32'd7);
    wb(4'd3, 32'h1234_5678);
    wb(4'd4, 32'hDEAD_BEEF);
    wb(4'd5, 32'hFFFF_FFFF);
    wb(4'd6, 32'h8000_0001);

    // Back-to-back independent words: one per cycle.
    for (int i = 0; i < 6; i++) begin
      in_valid = 1'b1; instr = vec[i].word;
      #1;
      check($sformatf("table_in_ready_%0d", i), 32'(in_ready), 32'd1);
      exp_q.push_back(vec[i].exp);
      tick();
      check($sformatf("table_out_valid_%0d", i), 32'(out_valid), 32'd1);
    end
    in_valid = 1'b0;
    tick();
    for (int r = 7; r <= 11; r++) wb(4'(r), 32'd0);

    // RAW stall released by writeback with bypass.
    in_valid = 1'b1; instr = 32'h0312_0000;
    #1; check("add_r3_in_ready", 32'(in_ready), 32'd1);
    exp_q.push_back(mkb(32'd5, 32'd7, 4'd0, 3'd0, 5'd0, 4'd3));
    tick();
    instr = 32'h1431_0000;
    for (int c = 0; c < 3; c++) begin
      #1; check("raw_stall_in_ready", 32'(in_ready), 32'd0);
      tick();
    end
    wb_en = 1'b1; wb_addr = 4'd3; wb_data = 32'd12;
    #1; check("raw_release_in_ready", 32'(in_ready), 32'd1);
    exp_q.push_back(mkb(32'd12, 32'd5, 4'd1, 3'd0, 5'd0, 4'd4));
    tick();
    wb_en = 1'b0;

    // WAW on r4, then same-cycle set/clear of r4 keeps it pending.
    instr = 32'h2412_0000;
    #1; check("waw_stall_in_ready", 32'(in_ready), 32'd0);
    tick();
    wb_en = 1'b1; wb_addr = 4'd4; wb_data = 32'h44;
    #1; check("waw_release_in_ready", 32'(in_ready), 32'd1);
    exp_q.push_back(mkb(32'd5, 32'd7, 4'd2, 3'd0, 5'd0, 4'd4));
    tick();
    wb_en = 1'b0;
    instr = 32'h0540_0000;
    #1; check("set_wins_in_ready", 32'(in_ready), 32'd0);
    tick();
    wb_en = 1'b1; wb_addr = 4'd4; wb_data = 32'h55;
    #1; check("set_wins_release", 32'(in_ready), 32'd1);
    exp_q.push_back(mkb(32'h55, 32'd0, 4'd0, 3'd0, 5'd0, 4'd5));
    tick();
    wb_en = 1'b0; in_valid = 1'b0;
    wb(4'd5, 32'h66);

    // Output held while the ALU side is not ready.
    out_ready = 1'b0;
    in_valid = 1'b1; instr = 32'h3612_2300;
    #1; check("hold_first_in_ready", 32'(in_ready), 32'd1);
    exp_q.push_back(mkb(32'd5, 32'd7, 4'd3, 3'd1, 5'd3, 4'd6));
    tick();
    instr = 32'h4712_0000;
    for (int c = 0; c < 3; c++) begin
      #1;
      check("hold_in_ready",  32'(in_ready),  32'd0);
      check("hold_out_valid", 32'(out_valid), 32'd1);
      check("hold_op_a",      op_a,           32'd5);
      check("hold_rd_out",    32'(rd_out),    32'd6);
      tick();
    end
    out_ready = 1'b1;
    #1; check("hold_release_in_ready", 32'(in_ready), 32'd1);
    exp_q.push_back(mkb(32'd5, 32'd7, 4'd4, 3'd0, 5'd0, 4'd7));
    tick();
    in_valid = 1'b0;
    tick();

    // Illegal opcodes are consumed without output or scoreboard effect.
    in_valid = 1'b1; instr = 32'hAC12_0000;
    #1; check("illegal_in_ready", 32'(in_ready), 32'd1);
    tick();
    in_valid = 1'b0;
    check("illegal_pulse",     32'(illegal_op), 32'd1);
    check("illegal_out_valid", 32'(out_valid),  32'd0);
    tick();
    check("illegal_pulse_end", 32'(illegal_op), 32'd0);
    in_valid = 1'b1; instr = 32'h6000_0000;
    tick();
    in_valid = 1'b0;
    check("illegal_0110_pulse", 32'(illegal_op), 32'd1);
    in_valid = 1'b1; instr = 32'h0CC0_0000;
    #1; check("no_pending_after_illegal", 32'(in_ready), 32'd1);
    exp_q.push_back(mkb(32'd0, 32'd0, 4'd0, 3'd0, 5'd0, 4'd12));
    tick();
    in_valid = 1'b0;
    check("legal_after_illegal_no_pulse", 32'(illegal_op), 32'd0);

    // r0 never stalls and never holds a value.
    wb(4'd0, 32'hFFFF_FFFF);
    for (int c = 0; c < 2; c++) begin
      in_valid = 1'b1; instr = 32'h0000_0000;
      #1; check("r0_in_ready", 32'(in_ready), 32'd1);
      exp_q.push_back(mkb(32'd0, 32'd0, 4'd0, 3'd0, 5'd0, 4'd0));
      tick();
    end
    wb_en = 1'b1; wb_addr = 4'd0; wb_data = 32'hFFFF_FFFF;
    instr = 32'h1000_0000;
    #1; check("r0_bypass_in_ready", 32'(in_ready), 32'd1);
    exp_q.push_back(mkb(32'd0, 32'd0, 4'd1, 3'd0, 5'd0, 4'd0));
    tick();
    wb_en = 1'b0; in_valid = 1'b0;
    tick();

    // Reset while holding a bundle with r3 pending.
    out_ready = 1'b0;
    in_valid = 1'b1; instr = 32'h0312_0000;
    #1; check("pre_reset_in_ready", 32'(in_ready), 32'd1);
    tick();
    in_valid = 1'b0;
    check("pre_reset_out_valid", 32'(out_valid), 32'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("mid_reset_out_valid", 32'(out_valid), 32'd0);
    check("mid_reset_op_a",      op_a,           32'd0);
    check("mid_reset_rd_out",    32'(rd_out),    32'd0);
    out_ready = 1'b1;
    in_valid = 1'b1; instr = 32'h1431_0000;
    #1; check("post_reset_no_stall", 32'(in_ready), 32'd1);
    exp_q.push_back(mkb(32'd0, 32'd0, 4'd1, 3'd0, 5'd0, 4'd4));
    tick();
    instr = 32'h2C67_0000;
    #1; check("post_reset_pending_clear", 32'(in_ready), 32'd1);
    exp_q.push_back(mkb(32'd0, 32'd0, 4'd2, 3'd0, 5'd0, 4'd12));
    tick();
    in_valid = 1'b0;
    wb(4'd3, 32'h33);
    in_valid = 1'b1; instr = 32'h0030_0000;
    #1; check("post_reset_wb_no_pending", 32'(in_ready), 32'd1);
    exp_q.push_back(mkb(32'h33, 32'd0, 4'd0, 3'd0, 5'd0, 4'd0));
    tick();
    in_valid = 1'b0;
    tick(); tick();
    check("queue_drained", 32'(exp_q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
